// File: rtl/mux_n_scan.sv
// Registered N-channel, WIDTH-bit selector with manual select and auto-scan modes.
// Latency: 1 cycle from data_in/sel/mode sampling to out/ch/valid/wrap.
// No backpressure: en gates all state updates, and valid drops while en is low.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   data_in  N channels flattened; channel k = data_in[k*WIDTH +: WIDTH]
//   sel      manual channel select (used when mode = 0)
//   mode     0 = manual, 1 = scan
//   en       global enable; when low, state holds and valid/wrap are forced low
//   hold     scan mode only: freeze channel stepping, keep tracking live data
//   out      registered data of the selected channel (0 for an illegal select)
//   ch       index of the channel currently on out
//   valid    out carries a legal channel's data
//   wrap     one-cycle pulse on the last dwell cycle of the last channel
module mux_n_scan #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int DWELL = 3,
   parameter int SEL_W = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]   sel,
   input  logic               mode,
   input  logic               en,
   input  logic               hold,
   output logic [WIDTH-1:0]   out,
   output logic [SEL_W-1:0]   ch,
   output logic               valid,
   output logic               wrap
);

   // Dwell counter needs at least one bit even when DWELL = 1.
   localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(N - 1);
   localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(DWELL - 1);

   logic [SEL_W-1:0] scan_idx;
   logic [DW_W-1:0]  dwell_cnt;
   logic             mode_q;

   logic             entering;
   logic [SEL_W-1:0] eff_idx;
   logic [DW_W-1:0]  eff_dwell;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_legal;
   logic [WIDTH-1:0] pick_dat;
   logic             last_dwell;
   logic             last_ch;
   logic [SEL_W-1:0] nxt_idx;
   logic [DW_W-1:0]  nxt_dwell;
   logic             nxt_wrap;

   // Channel pick and scan stepping.
   always_comb begin
      // A manual->scan transition (mode_q still 0) restarts the sweep at
      // channel 0 with a fresh dwell, whatever scan state was left behind.
      entering  = ~mode_q;
      eff_idx   = entering ? '0 : scan_idx;
      eff_dwell = entering ? '0 : dwell_cnt;

      pick_idx   = mode ? eff_idx : sel;
      pick_legal = (32'(pick_idx) < N);

      // Compare-and-select loop instead of a variable part-select, so an
      // out-of-range sel (non power-of-2 N) yields zeros rather than X.
      pick_dat = '0;
      for (int k = 0; k < N; k++) begin
         if (32'(pick_idx) == k) begin
            pick_dat = data_in[k*WIDTH +: WIDTH];
         end
      end

      last_dwell = (eff_dwell == LAST_DWELL);
      last_ch    = (eff_idx == LAST_IDX);

      nxt_idx   = eff_idx;
      nxt_dwell = eff_dwell;
      if (!hold) begin
         if (!last_dwell) begin
            nxt_dwell = eff_dwell + DW_W'(1);
         end else begin
            nxt_dwell = '0;
            nxt_idx   = last_ch ? '0 : eff_idx + SEL_W'(1);
         end
      end
      // hold wins over the final dwell cycle of the last channel.
      nxt_wrap = ~hold & last_ch & last_dwell;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out       <= '0;
         ch        <= '0;
         valid     <= 1'b0;
         wrap      <= 1'b0;
         scan_idx  <= '0;
         dwell_cnt <= '0;
         mode_q    <= 1'b0;
      end else if (!en) begin
         // Everything else holds, so scan resumes at the same dwell position.
         valid <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         mode_q <= mode;
         out    <= pick_legal ? pick_dat : '0;
         ch     <= pick_idx;
         valid  <= pick_legal;
         if (mode) begin
            scan_idx  <= nxt_idx;
            dwell_cnt <= nxt_dwell;
            wrap      <= nxt_wrap;
         end else begin
            // Scan state is kept but will be restarted on the next entry.
            wrap <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_scan.sv
module tb_mux_n_scan;

   typedef struct packed {
      logic [7:0] out;
      logic [1:0] ch;
      logic       valid;
      logic       wrap;
   } exp_t;

   logic        clk;
   logic        reset_n;

   // DUT A: N=4, DWELL=3
   logic [31:0] data4;
   logic [1:0]  sel4;
   logic        mode4, en4, hold4;
   logic [7:0]  out4;
   logic [1:0]  ch4;
   logic        valid4, wrap4;

   // DUT B: N=3, DWELL=1 (illegal select, every-cycle stepping)
   logic [23:0] data3;
   logic [1:0]  sel3;
   logic        mode3, en3, hold3;
   logic [7:0]  out3;
   logic [1:0]  ch3;
   logic        valid3, wrap3;

   exp_t q4[$];
   exp_t q3[$];

   int n_total = 0;
   int n_pass  = 0;

   mux_n_scan #(.N(4), .WIDTH(8), .DWELL(3), .SEL_W(2)) dut4 (
      .clk(clk), .reset_n(reset_n), .data_in(data4), .sel(sel4), .mode(mode4),
      .en(en4), .hold(hold4), .out(out4), .ch(ch4), .valid(valid4), .wrap(wrap4)
   );

   mux_n_scan #(.N(3), .WIDTH(8), .DWELL(1), .SEL_W(2)) dut3 (
      .clk(clk), .reset_n(reset_n), .data_in(data3), .sel(sel3), .mode(mode3),
      .en(en3), .hold(hold3), .out(out3), .ch(ch3), .valid(valid3), .wrap(wrap3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input exp_t act, input exp_t exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got out=%h ch=%0d valid=%b wrap=%b, want out=%h ch=%0d valid=%b wrap=%b",
                  name, act.out, act.ch, act.valid, act.wrap,
                  exp.out, exp.ch, exp.valid, exp.wrap);
      end else begin
         n_pass++;
      end
   endtask

   // Monitor: one registered result per clock; compare whenever one is owed.
   always @(posedge clk) begin
      exp_t a, e;
      #1;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         a = '{out4, ch4, valid4, wrap4};
         cmp("dut4_cycle", a, e);
      end
      if (q3.size() > 0) begin
         e = q3.pop_front();
         a = '{out3, ch3, valid3, wrap3};
         cmp("dut3_cycle", a, e);
      end
   end

   // Drive one cycle of inputs, queue the expected result, then move to the
   // next negedge so any setup done between calls applies to the next step.
   task automatic s4(input logic [1:0] s, input logic m, input logic e, input logic h,
                     input logic [7:0] eo, input logic [1:0] ec, input logic ev, input logic ew);
      sel4 = s; mode4 = m; en4 = e; hold4 = h;
      q4.push_back('{eo, ec, ev, ew});
      @(negedge clk);
   endtask

   task automatic s3(input logic [1:0] s, input logic m, input logic e, input logic h,
                     input logic [7:0] eo, input logic [1:0] ec, input logic ev, input logic ew);
      sel3 = s; mode3 = m; en3 = e; hold3 = h;
      q3.push_back('{eo, ec, ev, ew});
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      data4 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
      sel4 = 2'd2; mode4 = 1'b0; en4 = 1'b1; hold4 = 1'b0;
      data3 = {8'h33, 8'h22, 8'h11};
      sel3 = 2'd0; mode3 = 1'b0; en3 = 1'b1; hold3 = 1'b0;

      #12;
      cmp("reset4", '{out4, ch4, valid4, wrap4}, '{8'h00, 2'd0, 1'b0, 1'b0});
      cmp("reset3", '{out3, ch3, valid3, wrap3}, '{8'h00, 2'd0, 1'b0, 1'b0});
      @(negedge clk);
      reset_n = 1'b1;

      // Manual select
      s4(2, 0, 1, 0, 8'hCC, 2, 1, 0);
      s4(1, 0, 1, 0, 8'hBB, 1, 1, 0);
      s4(3, 0, 1, 0, 8'hDD, 3, 1, 0);

      // Full sweep from manual, wrap on third ch=3
      s4(3, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(3, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(3, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(3, 1, 1, 0, 8'hBB, 1, 1, 0);
      s4(3, 1, 1, 0, 8'hBB, 1, 1, 0);
      s4(3, 1, 1, 0, 8'hBB, 1, 1, 0);
      s4(3, 1, 1, 0, 8'hCC, 2, 1, 0);
      s4(3, 1, 1, 0, 8'hCC, 2, 1, 0);
      s4(3, 1, 1, 0, 8'hCC, 2, 1, 0);
      s4(3, 1, 1, 0, 8'hDD, 3, 1, 0);
      s4(3, 1, 1, 0, 8'hDD, 3, 1, 0);
      s4(3, 1, 1, 0, 8'hDD, 3, 1, 1);
      s4(3, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(3, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(3, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(3, 1, 1, 0, 8'hBB, 1, 1, 0);   // one dwell cycle used on ch1

      // Hold 5 cycles on ch1; channel 1 data changes mid-hold
      s4(3, 1, 1, 1, 8'hBB, 1, 1, 0);
      s4(3, 1, 1, 1, 8'hBB, 1, 1, 0);
      data4[15:8] = 8'h11;
      s4(3, 1, 1, 1, 8'h11, 1, 1, 0);
      s4(3, 1, 1, 1, 8'h11, 1, 1, 0);
      s4(3, 1, 1, 1, 8'h11, 1, 1, 0);
      data4[15:8] = 8'hBB;
      s4(3, 1, 1, 0, 8'hBB, 1, 1, 0);
      s4(3, 1, 1, 0, 8'hBB, 1, 1, 0);
      s4(3, 1, 1, 0, 8'hCC, 2, 1, 0);   // one dwell cycle used on ch2

      // Enable gating: frozen out/ch, valid and wrap low
      s4(0, 1, 0, 0, 8'hCC, 2, 0, 0);
      s4(0, 1, 0, 0, 8'hCC, 2, 0, 0);
      s4(0, 1, 0, 0, 8'hCC, 2, 0, 0);
      s4(0, 1, 0, 0, 8'hCC, 2, 0, 0);
      s4(3, 1, 1, 0, 8'hCC, 2, 1, 0);
      s4(3, 1, 1, 0, 8'hCC, 2, 1, 0);
      s4(3, 1, 1, 0, 8'hDD, 3, 1, 0);
      s4(3, 1, 1, 0, 8'hDD, 3, 1, 0);

      // Hold on the last dwell cycle of the last channel: no advance, no wrap
      s4(3, 1, 1, 1, 8'hDD, 3, 1, 0);
      s4(3, 1, 1, 0, 8'hDD, 3, 1, 1);
      s4(3, 1, 1, 0, 8'hAA, 0, 1, 0);

      // Scan -> manual -> scan restarts at ch0
      s4(1, 0, 1, 0, 8'hBB, 1, 1, 0);
      s4(1, 1, 1, 0, 8'hAA, 0, 1, 0);
      // Mode toggle while disabled is not seen: scan continues, no restart
      s4(1, 0, 0, 0, 8'hAA, 0, 0, 0);
      s4(1, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(1, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(1, 1, 1, 0, 8'hBB, 1, 1, 0);
      s4(1, 1, 1, 0, 8'hBB, 1, 1, 0);
      s4(1, 1, 1, 0, 8'hBB, 1, 1, 0);
      s4(1, 1, 1, 0, 8'hCC, 2, 1, 0);

      // Async reset between edges while ch=2
      #2;
      reset_n = 1'b0;
      #1;
      cmp("async_reset4", '{out4, ch4, valid4, wrap4}, '{8'h00, 2'd0, 1'b0, 1'b0});
      @(negedge clk);
      reset_n = 1'b1;
      s4(1, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(1, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(1, 1, 1, 0, 8'hAA, 0, 1, 0);
      s4(1, 1, 1, 0, 8'hBB, 1, 1, 0);
      en4 = 1'b0;

      // N=3 instance: illegal select and DWELL=1 scan
      s3(3, 0, 1, 0, 8'h00, 3, 0, 0);
      s3(2, 0, 1, 0, 8'h33, 2, 1, 0);
      s3(0, 0, 1, 0, 8'h11, 0, 1, 0);
      s3(3, 0, 1, 0, 8'h00, 3, 0, 0);
      s3(3, 1, 1, 0, 8'h11, 0, 1, 0);
      s3(3, 1, 1, 0, 8'h22, 1, 1, 0);
      s3(3, 1, 1, 0, 8'h33, 2, 1, 1);
      s3(3, 1, 1, 0, 8'h11, 0, 1, 0);
      s3(3, 1, 1, 1, 8'h22, 1, 1, 0);
      s3(3, 1, 1, 0, 8'h22, 1, 1, 0);
      s3(3, 1, 1, 0, 8'h33, 2, 1, 1);
      s3(3, 0, 1, 0, 8'h00, 3, 0, 0);

      repeat (3) @(negedge clk);
      n_total++;
      if (q4.size() + q3.size() != 0) begin
         $display("FAIL drain: got %0d expected results unchecked, want 0", q4.size() + q3.size());
      end else begin
         n_pass++;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mux_n_scan.md
Name: mux_n_scan

Overview:
- Registered, parametrised N-channel, WIDTH-bit selector; the next generation of the team's 4:1 combinational mux.
- Two modes:
  - Manual mode: channel chosen by `sel`.
  - Scan mode: an internal counter steps through all channels, dwelling DWELL cycles on each, and flags each full sweep.
- Feeds display/observation logic in the lab datapath, where several buses are time-shared onto one output.

Parameters:
- N, 4: number of input channels, N >= 2.
- WIDTH, 8: bits per channel.
- DWELL, 3: cycles spent on each channel in scan mode, DWELL >= 1.
- SEL_W, 2: select/index width, must equal clog2(N).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- data_in  in  N*WIDTH  flattened channels; channel k = data_in[k*WIDTH +: WIDTH].
- sel  in  SEL_W  manual channel select.
- mode  in  1  0 = manual, 1 = scan.
- en  in  1  global enable.
- hold  in  1  scan mode only: freeze channel stepping.
- out  out  WIDTH  registered selected data.
- ch  out  SEL_W  index of the channel currently on out.
- valid  out  1  out carries a legal channel's data.
- wrap  out  1  one-cycle pulse at end of a full scan sweep.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n; all state updates on the rising clk edge. reset_n low immediately forces:
  - out = 0, ch = 0, valid = 0, wrap = 0
  - scan_idx = 0, dwell_cnt = 0, mode_q = 0
- Release of reset_n is synchronous to clk in effect: the first update occurs at the first rising edge with reset_n high.
- en = 0:
  - out, ch, scan_idx, dwell_cnt and mode_q hold.
  - valid <= 0, wrap <= 0.
- Latency: 1 cycle. out/ch reflect data_in and selection sampled at the previous edge. No combinational path from inputs to outputs.
- Manual mode (en = 1, mode = 0):
  - If sel < N: out <= channel sel, ch <= sel, valid <= 1.
  - If sel >= N (possible only when N is not a power of 2): out <= 0, ch <= sel, valid <= 0. No X is ever driven.
  - wrap <= 0. scan_idx and dwell_cnt hold.
- Scan mode (en = 1, mode = 1):
  - entering = (mode_q == 0).
  - Effective index e = entering ? 0 : scan_idx.
  - Effective dwell d = entering ? 0 : dwell_cnt.
  - Every enabled scan cycle, regardless of hold: out <= channel e, ch <= e, valid <= 1.
  - If hold = 1: scan_idx <= e, dwell_cnt <= d, wrap <= 0. out keeps tracking live data of channel e.
  - Else if d < DWELL-1: dwell_cnt <= d+1, scan_idx <= e.
  - Else: dwell_cnt <= 0, scan_idx <= (e == N-1) ? 0 : e+1.
  - wrap <= (hold == 0) && (e == N-1) && (d == DWELL-1).
  - DWELL = 1: the index advances every enabled cycle.
- mode_q <= mode on every enabled edge.
- Mode transitions:
  - Manual to scan always restarts at channel 0 with a fresh dwell.
  - Scan to manual takes effect at the first edge; scan state is retained but restarted on next entry.
  - Toggling mode while en = 0 is not seen until en = 1.
- Reset mid-scan: outputs clear immediately; after release the next scan starts at channel 0.
- Simultaneous hold and last dwell cycle of channel N-1: hold wins; no advance, no wrap.

Test Plan:
- Reset and manual select. Stimulus: hold reset_n low, then release; N=4, WIDTH=8, data_in = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; sel = 2, mode = 0, en = 1. Required response: out = 0, valid = 0 during reset; one edge after release, out = 8'hCC, ch = 2, valid = 1.
- Scan sweep. Stimulus: DWELL = 3, mode = 1 from manual, run 12 cycles. Required response: ch sequence 0,0,0,1,1,1,2,2,2,3,3,3. wrap = 1 only on the edge where the third ch = 3 is registered, then the next ch = 0.
- Hold. Stimulus: assert hold for 5 cycles while ch = 1, with dwell partially used (1 cycle done). Required response: ch stays 1 throughout the hold; after release, 2 more cycles on channel 1 then ch = 2. Change channel 1 data during hold → out follows it with 1-cycle latency.
- Enable gating. Stimulus: en = 0 for 4 cycles mid-scan. Required response: out and ch frozen, valid = 0, wrap = 0; the scan resumes at the exact same dwell position.
- Illegal select. Stimulus: instance with N = 3, SEL_W = 2; sel = 3, mode = 0. Required response: out = 0, valid = 0, no X on any output.
- Async reset mid-scan. Stimulus: reset_n low between clock edges while ch = 2. Required response: outputs clear without waiting for a clock edge; after release with mode = 1, ch starts at 0.
